// File: rtl/regfile_sb.sv
// Parametrised integer register file with write-to-read bypass, optional hardwired
// zero register and a per-register pending scoreboard for issue/writeback tracking.
module regfile_sb #(
   parameter int unsigned XLEN     = 32,
   parameter int unsigned NREGS    = 32,
   parameter int unsigned BYPASS   = 1,
   parameter int unsigned ZERO_REG = 1,
   localparam int unsigned AW      = $clog2(NREGS)
) (
   input  logic            clk,
   input  logic            rst,
   input  logic [AW-1:0]   rs1,
   input  logic [AW-1:0]   rs2,
   output logic [XLEN-1:0] op1,
   output logic [XLEN-1:0] op2,
   output logic            busy1,
   output logic            busy2,
   input  logic            wr_en,
   input  logic [AW-1:0]   rd,
   input  logic [XLEN-1:0] in,
   input  logic            iss_en,
   input  logic [AW-1:0]   iss_rd,
   input  logic            flush,
   output logic [AW:0]     pend_cnt
);

   localparam int unsigned CW = AW + 1;

   logic [NREGS-1:0][XLEN-1:0] regs_q, regs_d;
   logic [NREGS-1:0]           pend_q, pend_d;
   logic [CW-1:0]              pend_cnt_q, pend_cnt_d;
   logic                       wr_live, iss_live;

   logic [AW-1:0]   rs_c   [2];
   logic [XLEN-1:0] op_c   [2];
   logic            busy_c [2];

   // Writes and issues aimed at a hardwired zero register are dropped.
   always_comb begin
      wr_live  = wr_en  && !((ZERO_REG != 0) && (rd == AW'(0)));
      iss_live = iss_en && !((ZERO_REG != 0) && (iss_rd == AW'(0)));
   end

   always_comb begin
      regs_d = regs_q;
      if (wr_live) regs_d[rd] = in;
   end

   // Clear at writeback, then set at issue so a new producer wins; flush overrides both.
   always_comb begin
      pend_d = pend_q;
      if (wr_en)    pend_d[rd]     = 1'b0;
      if (iss_live) pend_d[iss_rd] = 1'b1;
      if (flush)    pend_d         = '0;
      pend_cnt_d = '0;
      for (int unsigned i = 0; i < NREGS; i++) begin
         pend_cnt_d = pend_cnt_d + CW'(pend_d[i]);
      end
   end

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         regs_q     <= '0;
         pend_q     <= '0;
         pend_cnt_q <= '0;
      end else begin
         regs_q     <= regs_d;
         pend_q     <= pend_d;
         pend_cnt_q <= pend_cnt_d;
      end
   end

   // Read ports: stored value, optionally forwarded from writeback, zero reg and reset forced to 0.
   always_comb begin
      rs_c[0] = rs1;
      rs_c[1] = rs2;
      for (int p = 0; p < 2; p++) begin
         op_c[p]   = regs_q[rs_c[p]];
         busy_c[p] = pend_q[rs_c[p]];
         if ((BYPASS != 0) && wr_en && (rs_c[p] == rd)) begin
            op_c[p]   = in;
            busy_c[p] = 1'b0;
         end
         if ((ZERO_REG != 0) && (rs_c[p] == AW'(0))) begin
            op_c[p]   = '0;
            busy_c[p] = 1'b0;
         end
         if (!rst) begin
            op_c[p]   = '0;
            busy_c[p] = 1'b0;
         end
      end
   end

   assign op1      = op_c[0];
   assign op2      = op_c[1];
   assign busy1    = busy_c[0];
   assign busy2    = busy_c[1];
   assign pend_cnt = pend_cnt_q;

endmodule

// File: tb/tb_regfile_sb.sv
// Bench for regfile_sb: two instances (bypass+zero reg, plain) checked every cycle
// against a register/scoreboard model, plus literal expectations from the test plan.
module tb_regfile_sb;

   logic        clk = 1'b0;
   logic        rst = 1'b1;
   logic [4:0]  rs1 = '0, rs2 = '0, rd = '0, iss_rd = '0;
   logic        wr_en = 1'b0, iss_en = 1'b0, flush = 1'b0;
   logic [31:0] wdata = '0;

   logic [31:0] op1_a, op2_a, op1_b, op2_b;
   logic        busy1_a, busy2_a, busy1_b, busy2_b;
   logic [5:0]  cnt_a, cnt_b;

   int vectors = 0;
   int errors  = 0;
   bit chk_on  = 1'b0;

   always #5 clk = ~clk;

   regfile_sb #(.XLEN(32), .NREGS(32), .BYPASS(1), .ZERO_REG(1)) u_a (
      .clk(clk), .rst(rst), .rs1(rs1), .rs2(rs2), .op1(op1_a), .op2(op2_a),
      .busy1(busy1_a), .busy2(busy2_a), .wr_en(wr_en), .rd(rd), .in(wdata),
      .iss_en(iss_en), .iss_rd(iss_rd), .flush(flush), .pend_cnt(cnt_a));

   regfile_sb #(.XLEN(32), .NREGS(32), .BYPASS(0), .ZERO_REG(0)) u_b (
      .clk(clk), .rst(rst), .rs1(rs1), .rs2(rs2), .op1(op1_b), .op2(op2_b),
      .busy1(busy1_b), .busy2(busy2_b), .wr_en(wr_en), .rd(rd), .in(wdata),
      .iss_en(iss_en), .iss_rd(iss_rd), .flush(flush), .pend_cnt(cnt_b));

   // Model state: a = bypass + zero register, b = plain register file.
   logic [31:0] ma_reg [32];
   logic [31:0] mb_reg [32];
   logic [31:0] ma_pend, mb_pend, na_pend, nb_pend;

   always_comb begin
      na_pend = ma_pend;
      nb_pend = mb_pend;
      if (wr_en) begin
         na_pend[rd] = 1'b0;
         nb_pend[rd] = 1'b0;
      end
      if (iss_en) begin
         if (iss_rd != 5'd0) na_pend[iss_rd] = 1'b1;
         nb_pend[iss_rd] = 1'b1;
      end
      if (flush) begin
         na_pend = '0;
         nb_pend = '0;
      end
   end

   always @(posedge clk or negedge rst) begin
      if (!rst) begin
         for (int i = 0; i < 32; i++) begin
            ma_reg[i] <= '0;
            mb_reg[i] <= '0;
         end
         ma_pend <= '0;
         mb_pend <= '0;
      end else begin
         if (wr_en && rd != 5'd0) ma_reg[rd] <= wdata;
         if (wr_en) mb_reg[rd] <= wdata;
         ma_pend <= na_pend;
         mb_pend <= nb_pend;
      end
   end

   function automatic int popcnt(input logic [31:0] v);
      int n = 0;
      for (int i = 0; i < 32; i++) n += int'(v[i]);
      return n;
   endfunction

   function automatic logic [32:0] exp_a(input logic [4:0] rs);
      if (!rst || rs == 5'd0) return 33'd0;
      if (wr_en && rs == rd) return {1'b0, wdata};
      return {ma_pend[rs], ma_reg[rs]};
   endfunction

   function automatic logic [32:0] exp_b(input logic [4:0] rs);
      if (!rst) return 33'd0;
      return {mb_pend[rs], mb_reg[rs]};
   endfunction

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      vectors++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s at %0t: got 0x%08h, expected 0x%08h", name, $time, act, exp);
      end
   endtask

   // Per-cycle comparison against the model.
   always @(negedge clk) begin
      if (chk_on) begin
         logic [32:0] e;
         e = exp_a(rs1); check("a.op1", op1_a, e[31:0]); check("a.busy1", 32'(busy1_a), 32'(e[32]));
         e = exp_a(rs2); check("a.op2", op2_a, e[31:0]); check("a.busy2", 32'(busy2_a), 32'(e[32]));
         e = exp_b(rs1); check("b.op1", op1_b, e[31:0]); check("b.busy1", 32'(busy1_b), 32'(e[32]));
         e = exp_b(rs2); check("b.op2", op2_b, e[31:0]); check("b.busy2", 32'(busy2_b), 32'(e[32]));
         check("a.pend_cnt", 32'(cnt_a), 32'(popcnt(ma_pend)));
         check("b.pend_cnt", 32'(cnt_b), 32'(popcnt(mb_pend)));
      end
   end

   task automatic drive(input logic w, input int r, input logic [31:0] d, input logic i,
                        input int ir, input logic f, input int a, input int b);
      @(posedge clk);
      #1;
      wr_en = w; rd = 5'(r); wdata = d; iss_en = i; iss_rd = 5'(ir);
      flush = f; rs1 = 5'(a); rs2 = 5'(b);
   endtask

   task automatic settle();
      @(negedge clk);
      #1;
   endtask

   initial begin
      #1 rst = 1'b0;
      repeat (2) @(posedge clk);
      #1 rst = 1'b1;
      chk_on = 1'b1;

      // Load prior contents, then a one-cycle reset must wipe them.
      drive(1, 5, 32'hAAAA5555, 1, 5, 0, 5, 31);
      drive(1, 31, 32'h0F0F0F0F, 1, 31, 0, 5, 31);
      drive(0, 0, 0, 0, 0, 0, 5, 31);
      settle();
      check("lit.b.op1_pre", op1_b, 32'hAAAA5555);
      @(posedge clk); #1 rst = 1'b0;
      @(posedge clk); #1 rst = 1'b1;
      settle();
      check("lit.rst.op1", op1_a, 32'd0);
      check("lit.rst.op2", op2_a, 32'd0);
      check("lit.rst.busy1", 32'(busy1_a), 32'd0);
      check("lit.rst.cnt", 32'(cnt_a), 32'd0);

      // Bypass versus registered visibility.
      drive(1, 3, 32'hDEADBEEF, 0, 0, 0, 3, 3);
      settle();
      check("lit.byp.a_op1", op1_a, 32'hDEADBEEF);
      check("lit.byp.b_op1", op1_b, 32'd0);
      drive(0, 0, 0, 0, 0, 0, 3, 3);
      settle();
      check("lit.byp.b_op1_next", op1_b, 32'hDEADBEEF);

      // Zero register: discarded write, ignored issue.
      drive(1, 0, 32'h12345678, 0, 0, 0, 0, 0);
      settle();
      check("lit.zero.a_op1", op1_a, 32'd0);
      drive(0, 0, 0, 1, 0, 0, 0, 0);
      settle();
      check("lit.zero.a_op1_next", op1_a, 32'd0);
      check("lit.zero.b_op1_next", op1_b, 32'h12345678);
      drive(0, 0, 0, 0, 0, 0, 0, 0);
      settle();
      check("lit.zero.a_busy1", 32'(busy1_a), 32'd0);
      check("lit.zero.a_cnt", 32'(cnt_a), 32'd0);
      check("lit.zero.b_cnt", 32'(cnt_b), 32'd1);
      drive(0, 0, 0, 0, 0, 1, 0, 0);

      // Issue, same-register write+issue, flush.
      drive(0, 0, 0, 1, 7, 0, 7, 9);
      drive(0, 0, 0, 1, 9, 0, 7, 9);
      drive(0, 0, 0, 0, 0, 0, 7, 9);
      settle();
      check("lit.iss.cnt2", 32'(cnt_a), 32'd2);
      check("lit.iss.busy7", 32'(busy1_a), 32'd1);
      drive(1, 7, 32'h00000777, 1, 7, 0, 7, 9);
      drive(0, 0, 0, 0, 0, 0, 7, 9);
      settle();
      check("lit.setwins.busy7", 32'(busy1_a), 32'd1);
      check("lit.setwins.cnt", 32'(cnt_a), 32'd2);
      check("lit.setwins.data", op1_a, 32'h00000777);
      drive(0, 0, 0, 1, 11, 1, 7, 9);
      drive(0, 0, 0, 0, 0, 0, 7, 9);
      settle();
      check("lit.flush.cnt", 32'(cnt_a), 32'd0);
      check("lit.flush.busy1", 32'(busy1_a), 32'd0);
      check("lit.flush.busy2", 32'(busy2_a), 32'd0);

      // Fill the scoreboard, then mixed clear/set on different registers.
      for (int r = 1; r < 32; r++) drive(0, 0, 0, 1, r, 0, r, 31);
      drive(0, 0, 0, 0, 0, 0, 12, 9);
      settle();
      check("lit.full.a_cnt", 32'(cnt_a), 32'd31);
      check("lit.full.b_cnt", 32'(cnt_b), 32'd31);
      drive(1, 9, 32'h99999999, 1, 12, 0, 12, 9);
      drive(0, 0, 0, 0, 0, 0, 12, 9);
      settle();
      check("lit.mix.cnt", 32'(cnt_a), 32'd30);
      check("lit.mix.busy9", 32'(busy2_a), 32'd0);
      drive(0, 0, 0, 0, 0, 1, 0, 0);

      // Asynchronous reset in the middle of a write cycle.
      drive(1, 4, 32'h44444444, 1, 4, 0, 4, 5);
      #2 rst = 1'b0;
      #1;
      check("lit.arst.cnt", 32'(cnt_a), 32'd0);
      check("lit.arst.op1", op1_a, 32'd0);
      check("lit.arst.busy1", 32'(busy1_a), 32'd0);
      @(posedge clk);
      #1 wr_en = 1'b0; iss_en = 1'b0;
      #2 rst = 1'b1;
      settle();
      check("lit.arst.reg4", op1_a, 32'd0);
      check("lit.arst.b_reg4", op1_b, 32'd0);

      // Mixed traffic sweep, checked by the model.
      for (int i = 0; i < 40; i++) begin
         drive(i % 3 != 0, (i * 7) % 32, (32'(i) * 32'h01010101) ^ 32'hA5A5A5A5,
               i % 2 == 1, (i * 11 + 3) % 32, i == 25, (i * 5) % 32, (i * 13 + 1) % 32);
      end
      drive(0, 0, 0, 0, 0, 0, 0, 0);
      settle();

      $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
      $finish;
   end

endmodule
